// File: rtl/cp0_timer.sv
// cp0_timer: coprocessor-0 for the pipelined MIPS core, with a Count/Compare timer.
//
// Holds SR(12), Cause(13), EPC(14), PRId(15) and BadVAddr(8). When the timer is
// built in, it also holds Count(9) and Compare(11). The block sits beside the
// memory stage. It raises req combinationally, and it captures EPC, Cause and
// BadVAddr on the edge where req is taken.
//
// Optional feature: define CP0_TIMER_EN to build Count/Compare and the sticky
// timer interrupt TI (Cause[30]). Without it, addresses 9 and 11 read 0, writes
// to them are ignored, and TI is constant 0.
//
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   cp0_addr         register number for mfc0/mtc0
//   cp0_din, cp0_we  mtc0 data and enable (dropped when req=1)
//   cp0_dout         combinational read of cp0_addr, 0 for unmapped registers
//   pc, bd           memory-stage PC and branch-delay-slot flag
//   hwint            external interrupt levels
//   exc_code         pending exception code, 0 = none
//   bad_vaddr        faulting address for exc_code 4/5
//   exl_clr          eret committing
//   epc              current EPC
//   req              take exception/interrupt this cycle
//   timer_int        TI flag
module cp0_timer #(
  parameter int          NUM_HWINT   = 6,
  parameter int          TIMER_WIDTH = 32,
  parameter logic [31:0] PRID        = 32'h0000_4A37
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           cp0_addr,
  input  logic [31:0]          cp0_din,
  input  logic                 cp0_we,
  output logic [31:0]          cp0_dout,
  input  logic [31:0]          pc,
  input  logic                 bd,
  input  logic [NUM_HWINT-1:0] hwint,
  input  logic [4:0]           exc_code,
  input  logic [31:0]          bad_vaddr,
  input  logic                 exl_clr,
  output logic [31:0]          epc,
  output logic                 req,
  output logic                 timer_int
);

  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_SR       = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;
  localparam logic [4:0] A_PRID     = 5'd15;

  logic [31:0]          sr;
  logic [31:0]          sr_nxt;
  logic [31:0]          epc_q;
  logic [31:0]          bad_q;
  logic [NUM_HWINT-1:0] cause_ip;
  logic                 cause_bd;
  logic [4:0]           cause_exc;
  logic [31:0]          cause_rd;
  logic                 ti;
  logic [31:0]          count_rd;
  logic [31:0]          compare_rd;

  logic [NUM_HWINT-1:0] ip;
  logic [NUM_HWINT-1:0] im;
  logic                 exl;
  logic                 ie;
  logic                 interrupt;
  logic                 exception;
  logic                 wr_ok;

  // TI shares the top interrupt line with the highest external input.
  always_comb begin
    ip              = hwint;
    ip[NUM_HWINT-1] = hwint[NUM_HWINT-1] | ti;
  end

  assign im        = sr[10 +: NUM_HWINT];
  assign exl       = sr[1];
  assign ie        = sr[0];
  assign interrupt = (|(ip & im)) & ie & ~exl;
  assign exception = (exc_code != 5'd0) & ~exl;
  assign req       = interrupt | exception;
  assign wr_ok     = cp0_we & ~req;
  assign epc       = epc_q;
  assign timer_int = ti;

  // Taking req sets EXL and also overrides any eret in the same cycle.
  always_comb begin
    sr_nxt = sr;
    if (req) begin
      sr_nxt[1] = 1'b1;
    end else begin
      if (cp0_we && cp0_addr == A_SR) sr_nxt = cp0_din;
      if (exl_clr) sr_nxt[1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr        <= '0;
      epc_q     <= '0;
      bad_q     <= '0;
      cause_ip  <= '0;
      cause_bd  <= 1'b0;
      cause_exc <= '0;
    end else begin
      sr       <= sr_nxt;
      cause_ip <= ip;
      if (req) begin
        cause_bd  <= bd;
        cause_exc <= interrupt ? 5'd0 : exc_code;
        epc_q     <= bd ? (pc - 32'd4) : pc;
        if (!interrupt && (exc_code == 5'd4 || exc_code == 5'd5))
          bad_q <= bad_vaddr;
      end else if (cp0_we && cp0_addr == A_EPC) begin
        epc_q <= cp0_din;
      end
    end
  end

`ifdef CP0_TIMER_EN
  logic [TIMER_WIDTH-1:0] count;
  logic [TIMER_WIDTH-1:0] compare;

  // The compare happens against the current Count, so a Count write in the same
  // cycle cannot stop a match that is already present.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      compare <= '1;
      ti      <= 1'b0;
    end else begin
      if (wr_ok && cp0_addr == A_COUNT) count <= cp0_din[TIMER_WIDTH-1:0];
      else                              count <= count + TIMER_WIDTH'(1);
      if (wr_ok && cp0_addr == A_COMPARE) begin
        compare <= cp0_din[TIMER_WIDTH-1:0];
        ti      <= 1'b0;
      end else if (count == compare) begin
        ti <= 1'b1;
      end
    end
  end

  assign count_rd   = 32'(count);
  assign compare_rd = 32'(compare);
`else
  assign ti         = 1'b0;
  assign count_rd   = '0;
  assign compare_rd = '0;
`endif

  always_comb begin
    cause_rd                   = '0;
    cause_rd[31]               = cause_bd;
    cause_rd[30]               = ti;
    cause_rd[10 +: NUM_HWINT]  = cause_ip;
    cause_rd[6:2]              = cause_exc;
  end

  always_comb begin
    case (cp0_addr)
      A_BADVADDR: cp0_dout = bad_q;
      A_COUNT:    cp0_dout = count_rd;
      A_COMPARE:  cp0_dout = compare_rd;
      A_SR:       cp0_dout = sr;
      A_CAUSE:    cp0_dout = cause_rd;
      A_EPC:      cp0_dout = epc_q;
      A_PRID:     cp0_dout = PRID;
      default:    cp0_dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_timer.sv
// tb_cp0_timer: scoreboard bench for cp0_timer.
// Expectations are queued as stimulus is applied and checked once the DUT
// has produced them. A second 8-bit-timer instance exercises Count wrap and the
// Compare-write/match collision; it is only present when CP0_TIMER_EN is defined.
`timescale 1ns/1ps
module tb_cp0_timer;

  localparam logic [31:0] PRID_V = 32'h0000_4A37;

  localparam int K_DOUT  = 0;
  localparam int K_DOUT8 = 1;
  localparam int K_REQ   = 2;
  localparam int K_EPC   = 3;
  localparam int K_TI    = 4;
  localparam int K_TI8   = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_din;
  logic        cp0_we;
  logic        cp0_we8;
  logic [31:0] cp0_dout;
  logic [31:0] cp0_dout8;
  logic [31:0] pc;
  logic        bd;
  logic [5:0]  hwint;
  logic [4:0]  exc_code;
  logic [31:0] bad_vaddr;
  logic        exl_clr;
  logic [31:0] epc;
  logic [31:0] epc8;
  logic        req;
  logic        req8;
  logic        timer_int;
  logic        timer_int8;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    int          kind;
    logic [4:0]  addr;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  always #50 clk = ~clk;

  cp0_timer u_dut (
    .clk       (clk),
    .reset     (reset),
    .cp0_addr  (cp0_addr),
    .cp0_din   (cp0_din),
    .cp0_we    (cp0_we),
    .cp0_dout  (cp0_dout),
    .pc        (pc),
    .bd        (bd),
    .hwint     (hwint),
    .exc_code  (exc_code),
    .bad_vaddr (bad_vaddr),
    .exl_clr   (exl_clr),
    .epc       (epc),
    .req       (req),
    .timer_int (timer_int)
  );

`ifdef CP0_TIMER_EN
  cp0_timer #(.TIMER_WIDTH(8)) u_dut8 (
    .clk       (clk),
    .reset     (reset),
    .cp0_addr  (cp0_addr),
    .cp0_din   (cp0_din),
    .cp0_we    (cp0_we8),
    .cp0_dout  (cp0_dout8),
    .pc        (pc),
    .bd        (bd),
    .hwint     (hwint),
    .exc_code  (exc_code),
    .bad_vaddr (bad_vaddr),
    .exl_clr   (exl_clr),
    .epc       (epc8),
    .req       (req8),
    .timer_int (timer_int8)
  );
`else
  assign cp0_dout8  = '0;
  assign epc8       = '0;
  assign req8       = 1'b0;
  assign timer_int8 = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_v(input string tag, input int kind, input logic [4:0] addr,
                          input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.addr = addr;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [4:0]  save_addr;
    logic [31:0] obs;
    save_addr = cp0_addr;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.kind == K_DOUT || e.kind == K_DOUT8) cp0_addr = e.addr;
      #1;
      case (e.kind)
        K_DOUT:  obs = cp0_dout;
        K_DOUT8: obs = cp0_dout8;
        K_REQ:   obs = {31'b0, req};
        K_EPC:   obs = epc;
        K_TI:    obs = {31'b0, timer_int};
        default: obs = {31'b0, timer_int8};
      endcase
      chk(e.tag, obs, e.exp);
    end
    cp0_addr = save_addr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sel bit 0 writes the main instance, sel bit 1 writes the 8-bit instance.
  task automatic wr(input logic [4:0] addr, input logic [31:0] data, input logic [1:0] sel);
    cp0_addr = addr;
    cp0_din  = data;
    cp0_we   = sel[0];
    cp0_we8  = sel[1];
    step();
    cp0_we   = 1'b0;
    cp0_we8  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cp0_addr = '0; cp0_din = '0; cp0_we = 1'b0; cp0_we8 = 1'b0;
    pc = '0; bd = 1'b0; hwint = '0; exc_code = '0; bad_vaddr = '0; exl_clr = 1'b0;
    step(); step();

    expect_v("rst_sr",    K_DOUT, 5'd12, 32'h0);
    expect_v("rst_cause", K_DOUT, 5'd13, 32'h0);
    expect_v("rst_epc",   K_DOUT, 5'd14, 32'h0);
    expect_v("rst_bad",   K_DOUT, 5'd8,  32'h0);
    expect_v("rst_count", K_DOUT, 5'd9,  32'h0);
`ifdef CP0_TIMER_EN
    expect_v("rst_compare", K_DOUT, 5'd11, 32'hFFFF_FFFF);
`else
    expect_v("rst_compare", K_DOUT, 5'd11, 32'h0);
`endif
    expect_v("rst_req",   K_REQ, 5'd0, 32'h0);
    expect_v("rst_epcout", K_EPC, 5'd0, 32'h0);
    expect_v("rst_ti",    K_TI,  5'd0, 32'h0);
    drain();
    reset = 1'b0;

    // Masked interrupt, then unmask.
    hwint = 6'b000100;
    wr(5'd12, 32'h0000_0401, 2'b01);
    expect_v("irq_masked_req", K_REQ,  5'd0,  32'h0);
    expect_v("irq_cause_ip",   K_DOUT, 5'd13, 32'h0000_1000);
    drain();
    pc = 32'h0000_0100;
    wr(5'd12, 32'h0000_1001, 2'b01);
    expect_v("irq_req", K_REQ, 5'd0, 32'h1);
    drain();
    step();
    expect_v("irq_sr_exl",  K_DOUT, 5'd12, 32'h0000_1003);
    expect_v("irq_cause",   K_DOUT, 5'd13, 32'h0000_1000);
    expect_v("irq_epc",     K_DOUT, 5'd14, 32'h0000_0100);
    expect_v("irq_epc_out", K_EPC,  5'd0,  32'h0000_0100);
    expect_v("irq_exl_mask", K_REQ, 5'd0,  32'h0);
    drain();

    hwint = '0;
    exl_clr = 1'b1; step(); exl_clr = 1'b0;
    expect_v("eret_sr",    K_DOUT, 5'd12, 32'h0000_1001);
    expect_v("eret_cause", K_DOUT, 5'd13, 32'h0);
    drain();

    // Address error in a delay slot.
    exc_code = 5'd5; bd = 1'b1; pc = 32'h0000_3008; bad_vaddr = 32'h0000_0003;
    expect_v("exc_req", K_REQ, 5'd0, 32'h1);
    drain();
    step();
    exc_code = 5'd0; bd = 1'b0;
    expect_v("exc_epc",   K_DOUT, 5'd14, 32'h0000_3004);
    expect_v("exc_cause", K_DOUT, 5'd13, 32'h8000_0014);
    expect_v("exc_bad",   K_DOUT, 5'd8,  32'h0000_0003);
    drain();
    exc_code = 5'd8; pc = 32'h0000_4000; bad_vaddr = 32'h0000_0077;
    expect_v("exc2_masked", K_REQ, 5'd0, 32'h0);
    drain();
    step();
    exc_code = 5'd0;
    expect_v("exc2_cause", K_DOUT, 5'd13, 32'h8000_0014);
    expect_v("exc2_epc",   K_DOUT, 5'd14, 32'h0000_3004);
    expect_v("exc2_bad",   K_DOUT, 5'd8,  32'h0000_0003);
    drain();

    // eret and exception in the same cycle, with a concurrent mtc0 to EPC.
    exl_clr = 1'b1; step(); exl_clr = 1'b0;
    exl_clr = 1'b1; exc_code = 5'd10; pc = 32'h0000_0200;
    cp0_addr = 5'd14; cp0_din = 32'hDEAD_0000; cp0_we = 1'b1;
    expect_v("coll_req", K_REQ, 5'd0, 32'h1);
    drain();
    step();
    exl_clr = 1'b0; exc_code = 5'd0; cp0_we = 1'b0;
    expect_v("coll_sr",    K_DOUT, 5'd12, 32'h0000_1003);
    expect_v("coll_cause", K_DOUT, 5'd13, 32'h0000_0028);
    expect_v("coll_epc",   K_DOUT, 5'd14, 32'h0000_0200);
    drain();

    // Read-only and unmapped registers.
    expect_v("rd_prid",  K_DOUT, 5'd15, PRID_V);
    expect_v("rd_cause", K_DOUT, 5'd13, 32'h0000_0028);
    expect_v("rd_unmap", K_DOUT, 5'd7,  32'h0);
    drain();
    wr(5'd15, 32'h1234_5678, 2'b01);
    wr(5'd13, 32'hFFFF_FFFF, 2'b01);
    expect_v("ro_prid",  K_DOUT, 5'd15, PRID_V);
    expect_v("ro_cause", K_DOUT, 5'd13, 32'h0000_0028);
    drain();

`ifdef CP0_TIMER_EN
    wr(5'd12, 32'h0000_8001, 2'b01);
    pc = 32'h0000_0500;
    wr(5'd9, 32'd100, 2'b01);
    wr(5'd11, 32'd20, 2'b01);
    wr(5'd9, 32'd15, 2'b01);
    expect_v("tmr_count", K_DOUT, 5'd9, 32'd15);
    drain();
    repeat (5) step();
    expect_v("tmr_ti_early", K_TI, 5'd0, 32'h0);
    drain();
    step();
    expect_v("tmr_ti_set", K_TI,  5'd0, 32'h1);
    expect_v("tmr_req",    K_REQ, 5'd0, 32'h1);
    drain();
    step();
    expect_v("tmr_ti_hold", K_TI,   5'd0,  32'h1);
    expect_v("tmr_cause",   K_DOUT, 5'd13, 32'h4000_8000);
    expect_v("tmr_sr",      K_DOUT, 5'd12, 32'h0000_8003);
    expect_v("tmr_epc",     K_DOUT, 5'd14, 32'h0000_0500);
    drain();
    wr(5'd11, 32'd1000, 2'b01);
    expect_v("tmr_ti_clr",  K_TI,   5'd0,  32'h0);
    expect_v("tmr_compare", K_DOUT, 5'd11, 32'd1000);
    drain();

    wr(5'd9, 32'hFFFF_FFFF, 2'b11);
    expect_v("wrap32_pre", K_DOUT,  5'd9, 32'hFFFF_FFFF);
    expect_v("wrap8_pre",  K_DOUT8, 5'd9, 32'h0000_00FF);
    drain();
    step();
    expect_v("wrap32", K_DOUT,  5'd9, 32'h0);
    expect_v("wrap8",  K_DOUT8, 5'd9, 32'h0);
    drain();

    wr(5'd11, 32'd50, 2'b10);
    wr(5'd9, 32'd49, 2'b10);
    step();
    wr(5'd11, 32'd100, 2'b10);
    expect_v("cmp_coll_ti8", K_TI8,   5'd0,  32'h0);
    expect_v("cmp_coll_val", K_DOUT8, 5'd11, 32'd100);
    drain();
    wr(5'd9, 32'd99, 2'b10);
    step(); step();
    expect_v("match_ti8", K_TI8, 5'd0, 32'h1);
    drain();
`else
    wr(5'd9, 32'd123, 2'b01);
    wr(5'd11, 32'd5, 2'b01);
    expect_v("notmr_count",   K_DOUT, 5'd9,  32'h0);
    expect_v("notmr_compare", K_DOUT, 5'd11, 32'h0);
    expect_v("notmr_ti",      K_TI,   5'd0,  32'h0);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
